// File: rtl/div_unit.sv
// Signed 32-bit restoring divider with MIPS DIV semantics: quotient to lo, remainder to hi.
// 32 iterations on magnitudes, then a sign fix-up cycle. Divide-by-zero raises a one-cycle exception.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, DZ} state_t;

  state_t      state_q, state_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        signQ_q, signQ_d;
  logic        signR_q, signR_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [33:0] remShift;
  logic [33:0] trial;
  logic [31:0] absA;
  logic [31:0] absB;

  assign absA     = a[31] ? (~a + 32'd1) : a;
  assign absB     = b[31] ? (~b + 32'd1) : b;
  assign remShift = {rem_q, quo_q[31]};
  assign trial    = remShift - {2'b00, divisor_q};

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    signQ_d   = signQ_q;
    signR_d   = signR_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b != 32'd0) begin
            divisor_d = absB;
            quo_d     = absA;
            signQ_d   = a[31] ^ b[31];
            signR_d   = a[31];
            rem_d     = 33'd0;
            cnt_d     = 5'd0;
            state_d   = RUN;
          end else begin
            state_d = DZ;
          end
        end
      end
      RUN: begin
        // Restoring step: keep the trial difference only when it did not go negative
        if (!trial[33]) begin
          rem_d = trial[32:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = remShift[32:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = signR_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        lo_d    = signQ_q ? (~quo_q + 32'd1) : quo_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      DZ:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are flops; done/div_zero are timed off the state being left
  always_comb begin
    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_q == FIX) || (state_q == DZ);
    dz_d   = (state_q == DZ);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      divisor_q <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 33'd0;
      cnt_q     <= 5'd0;
      signQ_q   <= 1'b0;
      signR_q   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      signQ_q   <= signQ_d;
      signR_q   <= signR_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset as elsewhere in the CPU.
REQ-002 clock  input  1  rising-edge clock shared with the CPU datapath.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division, driven by the control unit for a DIV instruction; sampled only in IDLE.
REQ-005 a  input  32  dividend, from register A.
REQ-006 b  input  32  divisor, from register B.
REQ-007 hi  output  32  remainder; feeds the DivCtrl (HI) mux.
REQ-008 lo  output  32  quotient; feeds the MultCtrl (LO) mux.
REQ-009 busy  output  1  division in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 div_zero  output  1  one-cycle divide-by-zero exception pulse, to the control unit.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN, FIX, DONE and DZ.
REQ-013 IDLE: on a rising edge with start=1 and b!=0, SHALL latch a and b, store |a| and |b| as unsigned values, record sign_q=a[31]^b[31] and sign_r=a[31], clear the 33-bit partial remainder, set the iteration counter to 0, and go to RUN.
REQ-014 IDLE: on a rising edge with start=1 and b==0, SHALL go to DZ without modifying hi or lo.
REQ-015 RUN: each edge SHALL perform one restoring-division step.
- shift {rem, quotient} left by 1, bringing in the next dividend MSB;
- trial-subtract |b|; if the result is non-negative, keep it and set the quotient LSB to 1, otherwise restore and set the LSB to 0;
- increment the counter.
REQ-016 RUN: after 32 steps (counter wrap from 31) the FSM SHALL go to FIX.
REQ-017 FIX: on the next edge hi SHALL be loaded with the remainder, negated if sign_r=1, and lo with the quotient, negated if sign_q=1; the FSM then goes to DONE.
REQ-018 DONE: done SHALL be 1 for exactly one cycle; the next edge returns the FSM to IDLE.
REQ-019 DZ: div_zero and done SHALL both be 1 for exactly one cycle; the next edge returns the FSM to IDLE.
REQ-020 busy SHALL be 1 exactly in RUN and FIX.
REQ-021 Latency: with the start-sampling edge as E0, hi and lo SHALL update at E33 and done SHALL be high from E33 to E34; for divide-by-zero, done and div_zero SHALL be high from E1 to E2.
REQ-022 Signed semantics SHALL match MIPS DIV: the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-023 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000, with no exception.
REQ-024 Changes on a or b after E0 SHALL NOT affect the result.
REQ-025 start SHALL be ignored in RUN, FIX, DONE and DZ; a request asserted during those states is not queued.
REQ-026 hi and lo SHALL hold their value until the next FIX state or reset.
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from the inputs to the outputs.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, force the state to IDLE, set hi, lo and all internal registers to 0, and set busy, done and div_zero to 0.
REQ-029 A reset during RUN or FIX SHALL abort the operation, and no done pulse SHALL follow.
REQ-030 After reset is released, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-031 a=7, b=2, start pulsed at E0: lo=0x00000003 and hi=0x00000001 at E33; done high E33-E34; busy high E0-E33.
REQ-032 a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE (-2): lo=0xFFFFFFFD and hi=0x00000001.
REQ-033 Preload hi=1 and lo=3 via a prior division; then a=5, b=0, start: div_zero=1 and done=1 from E1 to E2, busy stays 0, hi=1 and lo=3 are unchanged.
REQ-034 a=0x80000000, b=0xFFFFFFFF: lo=0x80000000 and hi=0x00000000 at E33; div_zero stays 0.
REQ-035 Start 100/7, then assert reset between E10 and E11: hi=0, lo=0 and busy=0 immediately; no done pulse follows. After release, 100/7 gives lo=14 and hi=2.
REQ-036 Start 9/4, pulse start again at E5 with a=1, b=1, and change a to 0 at E3: the result is still lo=2 and hi=1, with exactly one done pulse.
